// File: rtl/flappy_pkg.sv
// Shared game constants and state encodings for the flappy pipe/bird blocks.
package flappy_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int FLOOR_Y    = 464;
  localparam int BIRD_SZ    = 16;
  localparam int PIPE_W     = 52;
  localparam int GAP_H      = 120;
  localparam int GAP_MIN    = 80;
  localparam int PIPE_START = 640;
  localparam int SPEED      = 2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  localparam logic [2:0] ST_I    = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_LOST = 3'b100;

  typedef enum logic [2:0] {
    S_I    = ST_I,
    S_RUN  = ST_RUN,
    S_LOST = ST_LOST
  } state_t;

  // Gap top edge from the random byte: 80..335 keeps the gap above the floor.
  function automatic logic [9:0] gap_from(input logic [7:0] r);
    return 10'(GAP_MIN) + {2'b00, r};
  endfunction

endpackage

// File: rtl/flappy_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, for pipe gap randomisation.
module flappy_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)   q <= SEED;
    else if (en) q <= {q[6:0], fb};
  end

endmodule

// File: rtl/flappy_pipe_ctrl.sv
// Scrolling pipe, gap randomisation, score and collision detection.
module flappy_pipe_ctrl
  import flappy_pkg::*;
#(
  parameter int         P_START = PIPE_START,
  parameter int         P_SPEED = SPEED,
  parameter logic [7:0] P_SEED  = LFSR_SEED
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Tick,
  input  logic [9:0] XBird,
  input  logic [9:0] YBird,
  output logic [9:0] XPipe,
  output logic [9:0] YGap,
  output logic [7:0] Score,
  output logic       Lost,
  output logic       q_I,
  output logic       q_Run,
  output logic       q_Lost
);

  state_t      state, state_nx;
  logic [9:0]  xpipe_nx, ygap_nx;
  logic [7:0]  score_nx;
  logic [7:0]  lfsr;

  logic [10:0] bird_r, pipe_r, bird_b, gap_b;
  logic        xov, yout, floor_hit, hit;

  flappy_lfsr8 #(.SEED(P_SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (1'b1),
    .q     (lfsr)
  );

  // 11-bit sums so edges near the right/bottom of the screen never wrap.
  assign bird_r = {1'b0, XBird} + 11'(BIRD_SZ);
  assign pipe_r = {1'b0, XPipe} + 11'(PIPE_W);
  assign bird_b = {1'b0, YBird} + 11'(BIRD_SZ);
  assign gap_b  = {1'b0, YGap}  + 11'(GAP_H);

  assign xov       = (bird_r > {1'b0, XPipe}) && ({1'b0, XBird} < pipe_r);
  assign yout      = (YBird < YGap) || (bird_b > gap_b);
  assign floor_hit = (YBird >= 10'(FLOOR_Y));
  assign hit       = (xov && yout) || floor_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_I;
      XPipe <= 10'(P_START);
      YGap  <= gap_from(P_SEED);
      Score <= '0;
    end else begin
      state <= state_nx;
      XPipe <= xpipe_nx;
      YGap  <= ygap_nx;
      Score <= score_nx;
    end
  end

  always_comb begin
    state_nx = state;
    xpipe_nx = XPipe;
    ygap_nx  = YGap;
    score_nx = Score;
    case (state)
      S_I: begin
        xpipe_nx = 10'(P_START);
        score_nx = '0;
        if (Start) begin
          state_nx = S_RUN;
          ygap_nx  = gap_from(lfsr);
        end
      end
      S_RUN: begin
        if (Tick) begin
          if (hit) begin
            state_nx = S_LOST;
          end else if (XPipe <= 10'(P_SPEED)) begin
            xpipe_nx = 10'(P_START);
            ygap_nx  = gap_from(lfsr);
            if (Score != 8'hFF) score_nx = Score + 8'd1;
          end else begin
            xpipe_nx = XPipe - 10'(P_SPEED);
          end
        end
      end
      S_LOST: begin
        if (Ack) begin
          state_nx = S_I;
          xpipe_nx = 10'(P_START);
          score_nx = '0;
        end
      end
      default: begin
        state_nx = S_I;
        xpipe_nx = 10'(P_START);
        score_nx = '0;
      end
    endcase
  end

  assign q_I    = (state == S_I);
  assign q_Run  = (state == S_RUN);
  assign q_Lost = (state == S_LOST);
  assign Lost   = q_Lost;

endmodule

// File: tb/tb_flappy_pipe_ctrl.sv
// Directed vector table plus hand sequences for flappy_pipe_ctrl.
module tb_flappy_pipe_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start, Ack, Tick;
  logic [9:0] XBird, YBird;
  logic [9:0] XPipe, YGap;
  logic [7:0] Score;
  logic       Lost, q_I, q_Run, q_Lost;

  logic       s2_start, s2_tick;
  logic [9:0] s2_xp, s2_yg;
  logic [7:0] s2_sc;
  logic       s2_lost, s2_qi, s2_qr, s2_ql;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  flappy_pipe_ctrl dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Ack    (Ack),
    .Tick   (Tick),
    .XBird  (XBird),
    .YBird  (YBird),
    .XPipe  (XPipe),
    .YGap   (YGap),
    .Score  (Score),
    .Lost   (Lost),
    .q_I    (q_I),
    .q_Run  (q_Run),
    .q_Lost (q_Lost)
  );

  // Short pipe run so 256 wraps fit in about a thousand ticks.
  flappy_pipe_ctrl #(.P_START(8)) dut_sat (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (s2_start),
    .Ack    (1'b0),
    .Tick   (s2_tick),
    .XBird  (10'd300),
    .YBird  (10'd200),
    .XPipe  (s2_xp),
    .YGap   (s2_yg),
    .Score  (s2_sc),
    .Lost   (s2_lost),
    .q_I    (s2_qi),
    .q_Run  (s2_qr),
    .q_Lost (s2_ql)
  );

  typedef struct {
    logic       start;
    logic       ack;
    logic       tick;
    logic [9:0] xb;
    logic [9:0] yb;
    int         reps;
    int         xp;
    int         sc;
    logic       lost;
    logic       qi;
    logic       qr;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int yb0;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 10'd144, 10'd0,   1,   640, 0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 10'd144, 10'd0,   241, 158, 0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 10'd144, 10'd0,   1,   158, 0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 10'd144, 10'd0,   5,   158, 0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 10'd144, 10'd0,   10,  158, 0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 10'd144, 10'd0,   1,   640, 0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 10'd144, 10'd0,   3,   640, 0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 10'd300, 10'd463, 1,   640, 0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 10'd300, 10'd463, 20,  600, 0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 10'd300, 10'd464, 1,   600, 0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 10'd300, 10'd100, 1,   640, 0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 10'd300, 10'd100, 1,   640, 0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 10'd300, 10'd100, 5,   640, 0, 1'b0, 1'b0, 1'b1};

    Reset = 1'b1;
    Start = 1'b0; Ack = 1'b0; Tick = 1'b0;
    XBird = 10'd800; YBird = 10'd100;
    s2_start = 1'b0; s2_tick = 1'b0;

    #3;
    chk("rst_xpipe", XPipe, 640);
    chk("rst_ygap", YGap, 245);
    chk("rst_score", Score, 0);
    chk("rst_lost", Lost, 0);
    chk("rst_qi", q_I, 1);
    chk("rst_qrun_qlost", {q_Run, q_Lost}, 0);
    #9 Reset = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < 13; i++) begin
      Start = tbl[i].start;
      Ack   = tbl[i].ack;
      Tick  = tbl[i].tick;
      XBird = tbl[i].xb;
      YBird = tbl[i].yb;
      repeat (tbl[i].reps) @(posedge Clk);
      #1;
      chk($sformatf("v%0d_xpipe", i), XPipe, tbl[i].xp);
      chk($sformatf("v%0d_score", i), Score, tbl[i].sc);
      chk($sformatf("v%0d_lost", i), Lost, tbl[i].lost);
      chk($sformatf("v%0d_qi", i), q_I, tbl[i].qi);
      chk($sformatf("v%0d_qrun", i), q_Run, tbl[i].qr);
    end

    // Three wraps plus 120 ticks, then asynchronous reset mid-RUN.
    Start = 1'b0; Ack = 1'b0;
    XBird = 10'd800; YBird = 10'd100; Tick = 1'b1;
    repeat (1080) @(posedge Clk);
    #1;
    chk("run_xpipe", XPipe, 400);
    chk("run_score", Score, 3);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_xpipe", XPipe, 640);
    chk("midrst_score", Score, 0);
    chk("midrst_ygap", YGap, 245);
    chk("midrst_lost", Lost, 0);
    chk("midrst_qi", q_I, 1);
    Tick = 1'b0;
    #3 Reset = 1'b0;
    @(posedge Clk); #1;

    // Full pipe crossing with the bird inside the gap, a tick every 4 clocks.
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("w_qrun", q_Run, 1);
    chk("w_gap_range", int'(YGap >= 10'd80 && YGap <= 10'd335), 1);
    yb0 = int'(YGap) + 40;
    XBird = 10'd300;
    YBird = 10'(yb0);
    for (int k = 1; k <= 320; k++) begin
      Tick = 1'b1;
      @(posedge Clk); #1;
      Tick = 1'b0;
      chk($sformatf("w%0d_xpipe", k), XPipe, (k == 320) ? 640 : 640 - 2 * k);
      chk($sformatf("w%0d_score", k), Score, (k == 320) ? 1 : 0);
      chk($sformatf("w%0d_lost", k), Lost, 0);
      repeat (3) @(posedge Clk);
      #1;
    end
    chk("w_gap_reload_range", int'(YGap >= 10'd80 && YGap <= 10'd335), 1);

    // Score saturation on the short-pipe instance.
    s2_start = 1'b1;
    @(posedge Clk); #1;
    s2_start = 1'b0;
    s2_tick  = 1'b1;
    repeat (4 * 254) @(posedge Clk);
    #1;
    chk("sat_254", s2_sc, 254);
    repeat (4) @(posedge Clk);
    #1;
    chk("sat_255", s2_sc, 255);
    chk("sat_xpipe", s2_xp, 8);
    repeat (4) @(posedge Clk);
    #1;
    chk("sat_hold", s2_sc, 255);
    repeat (8) @(posedge Clk);
    #1;
    chk("sat_hold2", s2_sc, 255);
    chk("sat_lost", s2_lost, 0);
    s2_tick = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
